cr_had_trace_ctrl: RTL and testbench

Sequencer for HAD instruction-trace debug entry. It owns the 8-bit trace counter, qualifies retire events from the IU, and counts down programmed retires. When the count is exhausted, it raises a debug-mode request and holds it until the core acknowledges by entering debug mode. It sits in the HAD core-side clock domain between the HAD register file and the HAD control path.

---
 rtl/cr_had_pkg.sv | 13 +
 rtl/cr_had_trace_ctrl_if.sv | 23 ++
 rtl/cr_had_trace_cnt.sv | 36 +++
 rtl/cr_had_trace_ctrl.sv | 89 ++++++++
 tb/tb_cr_had_trace_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/cr_had_pkg.sv
// rtl/cr_had_pkg.sv - shared HAD trace encodings and counter width default
package cr_had_pkg;

   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_REQ   = 2'b10,
      ST_DBG   = 2'b11
   } trace_state_e;

endpackage

// File: rtl/cr_had_trace_ctrl_if.sv
// rtl/cr_had_trace_ctrl_if.sv - IU retire/debug-status bus into the HAD trace sequencer
interface cr_had_trace_ctrl_if;

   logic iu_had_xx_retire;
   logic iu_had_xx_retire_normal;
   logic iu_had_xx_mldst;
   logic iu_yy_xx_dbgon;

   modport master (
      output iu_had_xx_retire,
      output iu_had_xx_retire_normal,
      output iu_had_xx_mldst,
      output iu_yy_xx_dbgon
   );

   modport slave (
      input  iu_had_xx_retire,
      input  iu_had_xx_retire_normal,
      input  iu_had_xx_mldst,
      input  iu_yy_xx_dbgon
   );

endinterface

// File: rtl/cr_had_trace_cnt.sv
// rtl/cr_had_trace_cnt.sv - trace retire counter: load, decrement saturating at 0, zero flag
module cr_had_trace_cnt
   import cr_had_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic             cpuclk,
   input  logic             cpurst_b,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_wdata,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_eq0
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_eq0;

   assign w_eq0 = (r_cnt == '0);

   // A load wins over a same-cycle decrement; zero never wraps.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_wdata;
      end else if (i_dec && !w_eq0) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;
   assign o_eq0 = w_eq0;

endmodule

// File: rtl/cr_had_trace_ctrl.sv
// rtl/cr_had_trace_ctrl.sv - HAD instruction-trace sequencer; counter present only with HAD_TRACE_CNT_EN
module cr_had_trace_ctrl
   import cr_had_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic                cpuclk,
   input  logic                cpurst_b,
   input  logic                regs_trace_en,
   input  logic                regs_trace_cnt_sel,
   input  logic [CNT_W-1:0]    regs_xx_wdata,
   cr_had_trace_ctrl_if.slave  iu,
   output logic [CNT_W-1:0]    trace_regs_counter,
   output logic                trace_dbg_req,
   output logic                trace_ctrl_req,
   output logic [1:0]          trace_state
);

   trace_state_e r_state;
   logic         r_dbg_req;
   logic         r_ctrl_req;
   logic         w_vld;
   logic         w_cnt_eq0;

   assign w_vld = iu.iu_had_xx_retire & iu.iu_had_xx_retire_normal & ~iu.iu_had_xx_mldst
                & regs_trace_en & ~iu.iu_yy_xx_dbgon & (r_state == ST_ARMED);

`ifdef HAD_TRACE_CNT_EN
   cr_had_trace_cnt #(.CNT_W(CNT_W)) u_cnt (
      .cpuclk   (cpuclk),
      .cpurst_b (cpurst_b),
      .i_load   (regs_trace_cnt_sel),
      .i_wdata  (regs_xx_wdata),
      .i_dec    (w_vld),
      .o_cnt    (trace_regs_counter),
      .o_eq0    (w_cnt_eq0)
   );
`else
   logic w_unused_cnt;
   assign w_unused_cnt       = ^{regs_trace_cnt_sel, regs_xx_wdata};
   assign trace_regs_counter = '0;
   assign w_cnt_eq0          = 1'b1;
`endif

   // Once in REQ the request is held until dbgon, regardless of trace enable.
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         r_state    <= ST_IDLE;
         r_dbg_req  <= 1'b0;
         r_ctrl_req <= 1'b0;
      end else begin
         r_ctrl_req <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (regs_trace_en && !iu.iu_yy_xx_dbgon) begin
                  r_state <= ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (!regs_trace_en) begin
                  r_state <= ST_IDLE;
               end else if (w_vld && w_cnt_eq0) begin
                  r_state    <= ST_REQ;
                  r_dbg_req  <= 1'b1;
                  r_ctrl_req <= 1'b1;
               end
            end
            ST_REQ: begin
               if (iu.iu_yy_xx_dbgon) begin
                  r_state   <= ST_DBG;
                  r_dbg_req <= 1'b0;
               end
            end
            ST_DBG: begin
               if (!iu.iu_yy_xx_dbgon) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign trace_dbg_req  = r_dbg_req;
   assign trace_ctrl_req = r_ctrl_req;
   assign trace_state    = r_state;

endmodule

// File: tb/tb_cr_had_trace_ctrl.sv
// tb/tb_cr_had_trace_ctrl.sv - directed vector bench for cr_had_trace_ctrl (both HAD_TRACE_CNT_EN builds)
module tb_cr_had_trace_ctrl;

   logic       cpuclk = 1'b0;
   logic       cpurst_b;
   logic       regs_trace_en;
   logic       regs_trace_cnt_sel;
   logic [7:0] regs_xx_wdata;
   logic [7:0] trace_regs_counter;
   logic       trace_dbg_req;
   logic       trace_ctrl_req;
   logic [1:0] trace_state;

   int n_cmp = 0;
   int n_err = 0;

   cr_had_trace_ctrl_if u_if ();

   cr_had_trace_ctrl #(.CNT_W(8)) u_dut (
      .cpuclk             (cpuclk),
      .cpurst_b           (cpurst_b),
      .regs_trace_en      (regs_trace_en),
      .regs_trace_cnt_sel (regs_trace_cnt_sel),
      .regs_xx_wdata      (regs_xx_wdata),
      .iu                 (u_if.slave),
      .trace_regs_counter (trace_regs_counter),
      .trace_dbg_req      (trace_dbg_req),
      .trace_ctrl_req     (trace_ctrl_req),
      .trace_state        (trace_state)
   );

   always #5 cpuclk = ~cpuclk;

   typedef struct {
      logic       sel;
      logic [7:0] wd;
      logic       en;
      logic       ret;
      logic       nrm;
      logic       mld;
      logic       dbg;
      logic [7:0] cnt;
      logic       dreq;
      logic       creq;
      logic [1:0] st;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic sel, input logic [7:0] wd, input logic en,
                        input logic ret, input logic nrm, input logic mld, input logic dbg);
      regs_trace_cnt_sel              = sel;
      regs_xx_wdata                   = wd;
      regs_trace_en                   = en;
      u_if.iu_had_xx_retire           = ret;
      u_if.iu_had_xx_retire_normal    = nrm;
      u_if.iu_had_xx_mldst            = mld;
      u_if.iu_yy_xx_dbgon             = dbg;
   endtask

   task automatic chk_all(input string tag, input logic [7:0] c, input logic d,
                          input logic r, input logic [1:0] s);
      chk({tag, ".cnt"},  32'(trace_regs_counter), 32'(c));
      chk({tag, ".dreq"}, 32'(trace_dbg_req),      32'(d));
      chk({tag, ".creq"}, 32'(trace_ctrl_req),     32'(r));
      chk({tag, ".st"},   32'(trace_state),        32'(s));
   endtask

   initial begin
      // columns: sel wd en ret nrm mld dbg | cnt dreq creq st
`ifdef HAD_TRACE_CNT_EN
      tbl.push_back('{1, 8'd3, 0, 0, 0, 0, 0,  8'd3, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd3, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 0,  8'd2, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 0,  8'd1, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 0,  8'd0, 1, 1, 2'd2});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 1, 0, 2'd2});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 1,  8'd0, 0, 0, 2'd3});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 1,  8'd0, 0, 0, 2'd3});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{1, 8'd2, 1, 0, 0, 0, 0,  8'd2, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 1, 0,  8'd2, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 0, 0, 0,  8'd2, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 0, 1, 1, 0, 0,  8'd2, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd2, 0, 0, 2'd1});
      tbl.push_back('{1, 8'd5, 1, 0, 0, 0, 0,  8'd5, 0, 0, 2'd1});
      tbl.push_back('{1, 8'd9, 1, 1, 1, 0, 0,  8'd9, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 1,  8'd9, 0, 0, 2'd1});
      tbl.push_back('{1, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{1, 8'd6, 1, 1, 1, 0, 0,  8'd6, 1, 1, 2'd2});
      tbl.push_back('{0, 8'd0, 0, 0, 0, 0, 0,  8'd6, 1, 0, 2'd2});
      tbl.push_back('{0, 8'd0, 0, 1, 1, 0, 0,  8'd6, 1, 0, 2'd2});
      tbl.push_back('{0, 8'd0, 0, 0, 0, 0, 1,  8'd6, 0, 0, 2'd3});
      tbl.push_back('{0, 8'd0, 0, 0, 0, 0, 0,  8'd6, 0, 0, 2'd0});
      tbl.push_back('{1, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd1});
`else
      tbl.push_back('{1, 8'd7, 0, 0, 0, 0, 0,  8'd0, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 1, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 0, 0, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 1,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{0, 8'd0, 1, 1, 1, 0, 0,  8'd0, 1, 1, 2'd2});
      tbl.push_back('{0, 8'd0, 0, 0, 0, 0, 0,  8'd0, 1, 0, 2'd2});
      tbl.push_back('{0, 8'd0, 0, 0, 0, 0, 1,  8'd0, 0, 0, 2'd3});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 1,  8'd0, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd1});
      tbl.push_back('{1, 8'd7, 1, 1, 1, 0, 0,  8'd0, 1, 1, 2'd2});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 1,  8'd0, 0, 0, 2'd3});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd0});
      tbl.push_back('{0, 8'd0, 1, 0, 0, 0, 0,  8'd0, 0, 0, 2'd1});
`endif

      drive(0, 8'd0, 0, 0, 0, 0, 0);
      cpurst_b = 1'b0;
      repeat (2) @(posedge cpuclk);
      #1;
      chk_all("reset", 8'd0, 1'b0, 1'b0, 2'd0);
      cpurst_b = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].sel, tbl[i].wd, tbl[i].en, tbl[i].ret, tbl[i].nrm, tbl[i].mld, tbl[i].dbg);
         @(posedge cpuclk);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].dreq, tbl[i].creq, tbl[i].st);
      end

      // From ARMED with counter 0: hold a retire until the request appears (bounded).
      begin
         int n_wait;
         n_wait = 0;
         drive(0, 8'd0, 1, 1, 1, 0, 0);
         while (trace_dbg_req !== 1'b1 && n_wait < 6) begin
            @(posedge cpuclk);
            #1;
            drive(0, 8'd0, 1, 0, 0, 0, 0);
            n_wait++;
         end
         chk("req_wait_ok", 32'(trace_dbg_req), 32'd1);
         chk("req_wait_lat", 32'(n_wait), 32'd1);
      end

      // Asynchronous reset in REQ clears everything without a clock edge.
      @(negedge cpuclk);
      cpurst_b = 1'b0;
      #1;
      chk_all("async_rst", 8'd0, 1'b0, 1'b0, 2'd0);
      @(negedge cpuclk);
      cpurst_b = 1'b1;
      drive(0, 8'd0, 1, 0, 0, 0, 0);
      @(posedge cpuclk);
      #1;
      chk_all("post_rst_arm", 8'd0, 1'b0, 1'b0, 2'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
